bcd_serial_adder_ctrl: RTL

Sequencer that adds two multi-digit BCD operands by time-sharing one single-digit BCD adder cell, one digit per clock, least-significant digit first. It sits between the switch/operand capture logic and the 7-segment display drivers. It owns the digit index, the inter-digit carry and the result register, and gives the rest of the design a start/done handshake.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adder.sv | 27 ++
 rtl/bcd_serial_adder_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the serial BCD adder.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [4:0] BCD_CORR  = 5'd6;
    localparam logic [4:0] BCD_MAX   = 5'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return ({1'b0, d} > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder cell; invalid digits take the same +6 correction.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [4:0] t;
    logic [4:0] t_corr;

    assign t      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign t_corr = t + BCD_CORR;

    always_comb begin
        digit = t[DIGIT_W-1:0];
        cout  = 1'b0;
        if (t > BCD_MAX) begin
            digit = t_corr[DIGIT_W-1:0];
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder that reuses one digit cell, LSD first, one digit per clock.
// Optional operand digit range check enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   a,
    input  logic [DIGIT_W*DIGITS-1:0]   b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   sum,
    output logic                        cout,
    output logic                        err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic               cout_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
    logic               dig_c;
    logic               last;
    logic               accept;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (idx == IDX_W'(DIGITS - 1));
    assign dig_a  = a_q[int'(idx)*DIGIT_W +: DIGIT_W];
    assign dig_b  = b_q[int'(idx)*DIGIT_W +: DIGIT_W];

    bcd_digit_adder u_cell (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (carry_q),
        .digit (dig_s),
        .cout  (dig_c)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_ADD;
            ST_ADD: begin
                busy = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operands are captured once per operation and need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            carry_q <= cin;
            sum_q   <= '0;
        end else if (state == ST_ADD) begin
            sum_q[int'(idx)*DIGIT_W +: DIGIT_W] <= dig_s;
            carry_q <= dig_c;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) cout_q <= dig_c;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_INPUT_CHECK_EN
    logic err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if (state == ST_ADD && (digit_invalid(dig_a) || digit_invalid(dig_b)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
